// File: rtl/value_uart_reporter_pkg.sv
// value_uart_reporter_pkg: shared FSM states, ASCII constants and hex encoding for the value reporter.
package value_uart_reporter_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam int MSG_CHARS = 4;
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
        return n <= 4'd9 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction
endpackage

// File: rtl/value_uart_reporter_tx.sv
// uart_tx_byte: 8N1 byte serialiser; a start presented on the final stop-bit cycle chains the next byte with no gap.
module uart_tx_byte
    import value_uart_reporter_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    state_t         state;
    logic [BW-1:0]  baud;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           bit_end;
    always_comb begin
        bit_end = baud == BW'(CLKS_PER_BIT - 1);
        done    = state == STOP && bit_end;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                state <= START;
                tx    <= 1'b0;
                shift <= data;
                baud  <= '0;
            end
        end else begin
            baud <= bit_end ? '0 : baud + 1'b1;
            if (bit_end) begin
                case (state)
                    START: begin
                        state   <= DATA;
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                        bit_idx <= '0;
                    end
                    DATA: begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end
                    default: begin
                        state <= start ? START : IDLE;
                        tx    <= ~start;
                        if (start) shift <= data;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/value_uart_reporter.sv
// value_uart_reporter: sends each new counter value as "HH\r\n" over 8N1 UART, coalescing changes while busy
// and pulsing missed for every change seen mid-message.
module value_uart_reporter
    import value_uart_reporter_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    output logic       tx,
    output logic       busy,
    output logic       missed
);
    logic [7:0] last_sent, value_prev, src, data;
    logic [1:0] char_idx, sel;
    logic       load, start, done;
    always_comb begin
        load  = !busy && value != last_sent;
        start = load || (done && char_idx != 2'(MSG_CHARS - 1));
        sel   = load ? 2'd0 : char_idx + 2'd1;
        src   = load ? value : last_sent;
        data  = sel == 2'd0 ? hex_to_ascii(src[7:4]) :
                sel == 2'd1 ? hex_to_ascii(src[3:0]) :
                sel == 2'd2 ? ASCII_CR : ASCII_LF;
    end
    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .data  (data),
        .tx    (tx),
        .done  (done)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_sent  <= 8'h00;
            value_prev <= 8'h00;
            missed     <= 1'b0;
            busy       <= 1'b0;
            char_idx   <= '0;
        end else begin
            value_prev <= value;
            missed     <= busy && value != value_prev;
            if (load) begin
                last_sent <= value;
                busy      <= 1'b1;
                char_idx  <= '0;
            end else if (done) begin
                if (char_idx == 2'(MSG_CHARS - 1)) busy <= 1'b0;
                else char_idx <= char_idx + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_value_uart_reporter.sv
// tb_value_uart_reporter: message-level reference model feeds an expected-byte queue; a UART decoder
// pops and compares each received byte, while per-cycle checks cover busy, missed and idle tx.
module tb_value_uart_reporter;
    localparam int CPB = 4;
    localparam int MSG_CYCLES = 40 * CPB;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] value = 8'h00;
    logic       tx, busy, missed;
    int         checks = 0, passes = 0, mcount = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_last = 8'h00, m_prev = 8'h00;
    int         m_rem = 0;
    logic       m_missed = 1'b0;
    bit         rst_flag = 1'b0;

    value_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .reset  (reset),
        .value  (value),
        .tx     (tx),
        .busy   (busy),
        .missed (missed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] hexc(input int n);
        return n < 10 ? 8'(48 + n) : 8'(65 + n - 10);
    endfunction

    // Reference: a message occupies MSG_CYCLES cycles; only the value seen when idle is reported.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_last = 8'h00; m_prev = 8'h00; m_rem = 0; m_missed = 1'b0;
            exp_q.delete();
            rst_flag = 1'b1;
        end else begin
            m_missed = (m_rem > 0) && value != m_prev;
            m_prev = value;
            if (m_rem > 0) m_rem--;
            else if (value != m_last) begin
                m_last = value;
                exp_q.push_back(hexc(int'(value) / 16));
                exp_q.push_back(hexc(int'(value) % 16));
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
                m_rem = MSG_CYCLES;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", int'(busy), int'(m_rem > 0));
        check("missed", int'(missed), int'(m_missed));
        if (m_rem == 0) check("tx_idle", int'(tx), 1);
        if (missed) mcount++;
    end

    // Decoder: samples every bit near its middle and abandons a byte cut by reset.
    initial begin
        logic [9:0] bits;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                rst_flag = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    repeat (k == 0 ? 1 : CPB) @(negedge clk);
                    if (rst_flag) break;
                    bits[k] = tx;
                end
                if (!rst_flag) begin
                    check("start_bit", int'(bits[0]), 0);
                    check("stop_bit", int'(bits[9]), 1);
                    check("byte_pending", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) check("byte", int'(bits[8:1]), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] v);
        @(negedge clk);
        #2 reset = 1'b1;
        value = v;
        cycles(2);
        #2 reset = 1'b0;
    endtask

    initial begin
        bit seen;
        cycles(3);
        #2 reset = 1'b0;
        cycles(200);
        check("quiet_missed", mcount, 0);
        value = 8'h3C;
        cycles(170);
        check("quiet_after_3c", int'(exp_q.size()), 0);

        do_reset(8'h3C);
        mcount = 0;
        cycles(20); value = 8'h3D;
        cycles(20); value = 8'h3E;
        cycles(400);
        check("missed_3d_3e", mcount, 2);

        do_reset(8'h3C);
        mcount = 0;
        cycles(20); value = 8'h41;
        cycles(20); value = 8'h3C;
        cycles(300);
        check("missed_41_3c", mcount, 2);

        do_reset(8'h3C);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = busy;
        end
        check("busy_rise", int'(seen), 1);
        cycles(57);
        #2 reset = 1'b1;
        #1;
        check("async_tx", int'(tx), 1);
        check("async_busy", int'(busy), 0);
        check("async_missed", int'(missed), 0);
        cycles(3);
        #2 reset = 1'b0;
        cycles(200);

        value = 8'h09; cycles(170);
        value = 8'hA5; cycles(170);
        value = 8'hFF; cycles(170);

        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) != 0) value = 8'($urandom_range(0, 255));
            cycles($urandom_range(1, 250));
        end
        cycles(400);
        check("leftover_bytes", int'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
